// File: rtl/cnn_stage_sequencer.sv
// Layer scheduler for the CNN pipeline: flushes the stage engines, launches each
// stage in order, waits for its done under a watchdog and records per-stage WAIT cycles.
module cnn_stage_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic [NUM_STAGES-1:0]         stage_start,
  output logic                          stage_rst_n,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  input  logic [$clog2(NUM_STAGES)-1:0] perf_sel,
  output logic [CNT_W-1:0]              perf_cycles
);

  localparam int SEL_W = $clog2(NUM_STAGES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(NUM_STAGES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [FL_W-1:0]         r_flush_cnt;
  logic                    r_abort;
  logic [WD_W-1:0]         r_wdog;
  logic [CNT_W-1:0]        r_cnt [NUM_STAGES];
  logic [SEL_W-1:0]        r_cur_stage;
  logic [SEL_W-1:0]        r_err_stage;
  logic [NUM_STAGES-1:0]   r_stage_start;
  logic                    r_stage_rst_n;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;

  logic                    w_cur_done;
  logic                    w_wd_expire;
  logic                    w_start_go;
  logic                    w_abort_go;
  logic [SEL_W-1:0]        w_next_cur;
  logic [NUM_STAGES-1:0]   w_stage_start_d;
  logic                    w_stage_rst_n_d;
  logic                    w_busy_d;
  logic                    w_done_d;
  logic                    w_error_d;

  assign w_cur_done  = stage_done[r_cur_stage];
  assign w_wd_expire = (r_wdog == WD_LAST);
  assign w_start_go  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_abort_go  = abort && ((r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_NEXT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // abort outranks a same-cycle done; done in the last watchdog cycle outranks the timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_FLUSH; else w_next_state = S_IDLE;
      S_FLUSH: begin
        if (r_flush_cnt == FL_LAST) w_next_state = r_abort ? S_IDLE : S_LAUNCH;
        else                        w_next_state = S_FLUSH;
      end
      S_LAUNCH: if (abort) w_next_state = S_FLUSH; else w_next_state = S_WAIT;
      S_WAIT: begin
        if (abort)                   w_next_state = S_FLUSH;
        else if (w_cur_done)         w_next_state = (r_cur_stage == LAST_STAGE) ? S_DONE : S_NEXT;
        else if (w_wd_expire)        w_next_state = S_ERROR;
        else                         w_next_state = S_WAIT;
      end
      S_NEXT:   if (abort) w_next_state = S_FLUSH; else w_next_state = S_LAUNCH;
      S_DONE:   if (start) w_next_state = S_FLUSH; else w_next_state = S_DONE;
      S_ERROR:  if (start) w_next_state = S_FLUSH; else w_next_state = S_ERROR;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it
  always_comb begin
    if (w_start_go) begin
      w_next_cur = '0;
    end else if ((r_state == S_NEXT) && !abort) begin
      w_next_cur = r_cur_stage + SEL_W'(1);
    end else begin
      w_next_cur = r_cur_stage;
    end
    if (w_next_state == S_LAUNCH) begin
      w_stage_start_d = NUM_STAGES'(1'b1) << w_next_cur;
    end else begin
      w_stage_start_d = '0;
    end
    w_stage_rst_n_d = (w_next_state != S_FLUSH);
    w_busy_d        = (w_next_state == S_FLUSH) || (w_next_state == S_LAUNCH) ||
                      (w_next_state == S_WAIT)  || (w_next_state == S_NEXT);
    w_done_d        = (w_next_state == S_DONE);
    w_error_d       = (w_next_state == S_ERROR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stage_start <= '0;
      r_stage_rst_n <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cur_stage   <= '0;
      r_err_stage   <= '0;
    end else begin
      r_stage_start <= w_stage_start_d;
      r_stage_rst_n <= w_stage_rst_n_d;
      r_busy        <= w_busy_d;
      r_done        <= w_done_d;
      r_error       <= w_error_d;
      r_cur_stage   <= w_next_cur;
      if ((r_state == S_WAIT) && (w_next_state == S_ERROR)) begin
        r_err_stage <= r_cur_stage;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flush_cnt <= '0;
      r_abort     <= 1'b0;
      r_wdog      <= '0;
    end else begin
      if ((r_state == S_FLUSH) && (w_next_state == S_FLUSH)) r_flush_cnt <= r_flush_cnt + FL_W'(1);
      else                                                  r_flush_cnt <= '0;
      if (w_abort_go)                                        r_abort <= 1'b1;
      else if ((r_state == S_FLUSH) && (w_next_state != S_FLUSH)) r_abort <= 1'b0;
      if (r_state == S_LAUNCH)     r_wdog <= '0;
      else if (r_state == S_WAIT)  r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // Per-stage WAIT-cycle counters, cleared on every run request and saturating
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_STAGES; i++) r_cnt[i] <= '0;
    end else if (w_start_go) begin
      for (int i = 0; i < NUM_STAGES; i++) r_cnt[i] <= '0;
    end else if ((r_state == S_WAIT) && (r_cnt[r_cur_stage] != CNT_MAX)) begin
      r_cnt[r_cur_stage] <= r_cnt[r_cur_stage] + CNT_W'(1);
    end
  end

  always_comb begin
    if (int'(perf_sel) < NUM_STAGES) perf_cycles = r_cnt[perf_sel];
    else                             perf_cycles = '0;
  end

  assign stage_start = r_stage_start;
  assign stage_rst_n = r_stage_rst_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign err_stage   = r_err_stage;
  assign cur_stage   = r_cur_stage;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer: table of run scenarios, random latencies against a
// run-level model, and a mid-run asynchronous reset sequence.
module tb_cnn_stage_sequencer;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       resetn, start, abort;
  logic [3:0] stage_done, stage_start;
  logic       stage_rst_n, busy, done, error;
  logic [1:0] err_stage, cur_stage, perf_sel;
  logic [31:0] perf_cycles;

  always #5 clk = ~clk;

  cnn_stage_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(T), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .stage_done(stage_done),
    .stage_start(stage_start), .stage_rst_n(stage_rst_n), .busy(busy), .done(done),
    .error(error), .err_stage(err_stage), .cur_stage(cur_stage), .perf_sel(perf_sel),
    .perf_cycles(perf_cycles));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct packed {
    logic [3:0][7:0] lat;      // WAIT cycle of done per stage; 0 = never
    logic [3:0]      ab_stage; // 15 = no abort
    logic [7:0]      ab_k;
    logic            foreign;  // hold stage_done[3] while stage 1 is awaited
    logic            e_done;
    logic            e_error;
    logic [1:0]      e_es;
  } vec_t;

  vec_t vecs [7];
  int lat [4];
  int ab_stage, ab_k;
  bit foreign;
  int exp_cnt [4];
  int exp_started, m_done, m_err, m_es;

  function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3,
                              input int abs, input int abk, input bit f,
                              input bit d, input bit e, input int es);
    vec_t v;
    v.lat[0] = 8'(l0); v.lat[1] = 8'(l1); v.lat[2] = 8'(l2); v.lat[3] = 8'(l3);
    v.ab_stage = 4'(abs); v.ab_k = 8'(abk); v.foreign = f;
    v.e_done = d; v.e_error = e; v.e_es = 2'(es);
    return v;
  endfunction

  // Run-level model: stages complete in order until one times out or is aborted
  task automatic model();
    for (int s = 0; s < 4; s++) exp_cnt[s] = 0;
    exp_started = 0; m_done = 0; m_err = 0; m_es = 0;
    for (int s = 0; s < 4; s++) begin
      exp_started++;
      if (s == ab_stage) break;
      if (lat[s] >= 1 && lat[s] <= T) begin
        exp_cnt[s] = lat[s];
        if (s == 3) m_done = 1;
      end else begin
        exp_cnt[s] = T; m_err = 1; m_es = s;
        break;
      end
    end
  endtask

  task automatic do_run(input string nm, input bit e_done, input bit e_err, input int e_es);
    int active = -1, k = 0, rst_low = 0, bad_pulse = 0, bad_cur = 0, bad_gap = 0, bad_order = 0;
    int last_done_cyc = -100, seen_end = 0, idx;
    logic [3:0] prev_start = 4'd0;
    int order [$];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!stage_rst_n) rst_low++;
      if (stage_start != 4'd0 && (prev_start != 4'd0 || $countones(stage_start) != 1)) bad_pulse++;
      prev_start = stage_start;
      if (!busy) begin seen_end = 1; break; end
      abort = 1'b0; stage_done = 4'd0;
      if (stage_start != 4'd0) begin
        idx = 0;
        for (int s = 0; s < 4; s++) if (stage_start[s]) idx = s;
        if (int'(cur_stage) != idx) bad_cur++;
        if (order.size() > 0 && cyc - last_done_cyc != 2) bad_gap++;
        order.push_back(idx);
        active = idx; k = 0;
      end else if (active >= 0) begin
        k++;
        if (active == ab_stage && k == ab_k) begin
          abort = 1'b1; stage_done[active] = 1'b1; active = -1;
        end else if (k == lat[active]) begin
          stage_done[active] = 1'b1; active = -1; last_done_cyc = cyc;
        end else if (foreign && active == 1) begin
          stage_done[3] = 1'b1;
        end
      end
      @(negedge clk);
    end
    abort = 1'b0; stage_done = 4'd0;
    for (int i = 0; i < order.size(); i++) if (order[i] != i) bad_order++;
    chk({nm, ".end"}, seen_end, 1);
    chk({nm, ".flush_len"}, rst_low, (ab_stage < 4) ? 4 : 2);
    chk({nm, ".pulse"}, bad_pulse, 0);
    chk({nm, ".cur_stage"}, bad_cur, 0);
    chk({nm, ".gap"}, bad_gap, 0);
    chk({nm, ".order"}, bad_order, 0);
    chk({nm, ".n_started"}, order.size(), exp_started);
    chk({nm, ".done"}, done, e_done);
    chk({nm, ".error"}, error, e_err);
    if (e_err) chk({nm, ".err_stage"}, err_stage, e_es);
    for (int s = 0; s < 4; s++) begin
      if (s == ab_stage) continue;
      perf_sel = 2'(s); #1;
      chk($sformatf("%s.cnt%0d", nm, s), perf_cycles, exp_cnt[s]);
    end
  endtask

  task automatic load(input vec_t v);
    for (int s = 0; s < 4; s++) lat[s] = int'(v.lat[s]);
    ab_stage = int'(v.ab_stage); ab_k = int'(v.ab_k); foreign = v.foreign;
  endtask

  initial begin
    vecs[0] = mk(10, 20, 5, 7, 15, 0, 1'b0, 1'b1, 1'b0, 0);
    vecs[1] = mk(3, 5, 0, 4, 15, 0, 1'b0, 1'b0, 1'b1, 2);
    vecs[2] = mk(1, 64, 2, 1, 15, 0, 1'b1, 1'b1, 1'b0, 0);
    vecs[3] = mk(2, 10, 5, 5, 1, 3, 1'b0, 1'b0, 1'b0, 0);
    vecs[4] = mk(64, 1, 1, 1, 15, 0, 1'b0, 1'b1, 1'b0, 0);
    vecs[5] = mk(0, 1, 1, 1, 15, 0, 1'b0, 1'b0, 1'b1, 0);
    vecs[6] = mk(5, 5, 5, 65, 15, 0, 1'b0, 1'b0, 1'b1, 3);

    resetn = 1'b0; start = 1'b0; abort = 1'b0; stage_done = 4'd0; perf_sel = 2'd0;
    #12;
    chk("rst.stage_start", stage_start, 0);
    chk("rst.stage_rst_n", stage_rst_n, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.err_stage", err_stage, 0);
    chk("rst.cur_stage", cur_stage, 0);
    chk("rst.perf", perf_cycles, 0);
    @(negedge clk); resetn = 1'b1;

    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort.busy", busy, 0);
    chk("idle_abort.rst_n", stage_rst_n, 1);

    for (int v = 0; v < 7; v++) begin
      load(vecs[v]); model();
      do_run($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_error, int'(vecs[v].e_es));
    end

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 4; s++) lat[s] = int'($urandom_range(70, 1));
      ab_stage = 15; ab_k = 0; foreign = 1'b0;
      model();
      do_run($sformatf("rnd%0d", r), m_done[0], m_err[0], m_es);
    end

    // Asynchronous reset between clock edges while stage 0 is being awaited
    for (int s = 0; s < 4; s++) lat[s] = 50;
    ab_stage = 15; foreign = 1'b0; perf_sel = 2'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid.busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst.stage_start", stage_start, 0);
    chk("mid_rst.stage_rst_n", stage_rst_n, 1);
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.done", done, 0);
    chk("mid_rst.error", error, 0);
    chk("mid_rst.err_stage", err_stage, 0);
    chk("mid_rst.cur_stage", cur_stage, 0);
    chk("mid_rst.perf", perf_cycles, 0);
    repeat (3) @(posedge clk);
    #1 chk("mid_rst.hold_rst_n", stage_rst_n, 1);
    @(negedge clk); resetn = 1'b1;

    load(vecs[0]); model();
    do_run("after_rst", 1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cnn_stage_sequencer.md
Name: cnn_stage_sequencer

Overview:
- Top-level layer scheduler for the MNIST CNN pipeline (conv1 -> maxpool1 -> conv2 -> ...).
- Launches each stage engine with a one-cycle start pulse and waits for that stage's done before launching the next.
- Enforces a per-stage watchdog, records per-stage cycle counts, and flushes the stage engines through a shared synchronous soft reset before every run.
- Sits between the SoC control registers and the chain of stage engines.

Parameters:
NUM_STAGES, 4, number of sequenced stages; stage i is launched only after stage i-1 completes
TIMEOUT_CYCLES, 1048576, maximum WAIT cycles allowed per stage before error
FLUSH_CYCLES, 2, number of cycles stage_rst_n is held low before a run
CNT_W, 32, width of the per-stage cycle counters

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  run request, sampled in IDLE, DONE and ERROR
abort  in  1  cancel the current run, sampled in LAUNCH, WAIT and NEXT
stage_done  in  NUM_STAGES  per-stage done; level or pulse accepted
stage_start  out  NUM_STAGES  one-hot single-cycle launch pulse
stage_rst_n  out  1  synchronous active-low soft reset to all stage engines
busy  out  1  high in FLUSH, LAUNCH, WAIT and NEXT
done  out  1  level; all stages completed
error  out  1  level; watchdog expired
err_stage  out  $clog2(NUM_STAGES)  index of the stage that timed out
cur_stage  out  $clog2(NUM_STAGES)  stage currently launched or awaited
perf_sel  in  $clog2(NUM_STAGES)  selects a cycle counter for readout
perf_cycles  out  CNT_W  combinational readout of the counter chosen by perf_sel

Behaviour:
- Reset (resetn low, asynchronous):
  - State = IDLE.
  - stage_start = 0, stage_rst_n = 1, busy = 0, done = 0, error = 0, err_stage = 0, cur_stage = 0.
  - All cycle counters = 0, watchdog = 0.
  - Reset mid-run aborts immediately; no flush pulse is generated.
- States: IDLE, FLUSH, LAUNCH, WAIT, NEXT, DONE, ERROR.
- IDLE:
  - start=1 -> FLUSH.
  - In the same transition: clear all cycle counters, clear done and error, set cur_stage=0.
- FLUSH:
  - stage_rst_n=0 for exactly FLUSH_CYCLES consecutive cycles, then LAUNCH.
  - start is ignored here.
- LAUNCH:
  - stage_start[cur_stage]=1 for exactly this cycle; all other bits are 0.
  - Clear the watchdog, then WAIT.
- WAIT:
  - Each cycle, increment the watchdog and counter[cur_stage]. The counter saturates at all-ones.
  - Only stage_done[cur_stage] is examined; done bits of other stages are ignored.
  - stage_done[cur_stage]=1: go to DONE if cur_stage==NUM_STAGES-1, otherwise go to NEXT.
  - The counter value is the number of WAIT cycles, including the cycle in which done is sampled. The minimum value is 1.
  - Watchdog timeout: if the watchdog reaches TIMEOUT_CYCLES and stage_done is still low, go to ERROR with err_stage=cur_stage.
  - done asserted in the TIMEOUT_CYCLES-th WAIT cycle wins over the timeout.
- NEXT:
  - cur_stage += 1, then LAUNCH.
  - This gives one idle gap cycle between the done sample and the next start pulse.
- DONE:
  - done=1 and busy=0; the state holds.
  - start=1 -> FLUSH, and done clears in the same transition.
- ERROR:
  - error=1 and busy=0; err_stage holds.
  - Counters are frozen; counter[err_stage] = TIMEOUT_CYCLES.
  - start=1 -> FLUSH, and error clears.
- abort=1 in LAUNCH, WAIT or NEXT:
  - Go to FLUSH with an internal abort flag set.
  - After the flush, go to IDLE (not LAUNCH). done and error stay 0.
  - abort has priority over stage_done in the same cycle.
- Other input rules:
  - abort in IDLE, DONE or ERROR is ignored.
  - start and abort high together in DONE: start wins.
- Output timing:
  - All outputs are registered except perf_cycles.
  - stage_start is registered, so it appears in the LAUNCH cycle.

Test Plan:
- Normal run: start pulse; stage models raise done on WAIT cycle 10, 20, 5, 7. Required: stage_rst_n low for 2 cycles; stage_start pulses occur in order 0..3, each exactly 1 cycle wide. done rises; perf_cycles reads 10, 20, 5, 7; busy is high throughout the run.
- Timeout: TIMEOUT_CYCLES=64; stage 2 never completes. Required: error=1 and err_stage=2 after 64 WAIT cycles; counter[2]=64; stage 3 is never started. A subsequent start flushes, clears error, and reruns from stage 0.
- Stale/foreign done: hold stage_done[3]=1 while stage 1 is active. Required: no early DONE transition and no stage skipped. Done on exactly WAIT cycle 64 with TIMEOUT_CYCLES=64 -> proceeds, no error.
- Abort: assert abort in WAIT of stage 1, together with stage_done[1]=1. Required: 2-cycle flush, then IDLE; done=0, error=0; stage_start[2] never asserted.
- Restart and reset: start in DONE -> counters cleared, full rerun. Drive resetn low mid-WAIT, asynchronously between clock edges. Required: outputs reach reset values immediately; stage_rst_n stays 1.
